bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-master arbiter that shares the CPU data bus (busWe/busAddr/busWData/memSize/busRData) between the multi-cycle RV32I core (master 0) and a DMA engine (master 1). It accepts one transaction at a time, picks a winner with round-robin priority, drives the shared bus until the slave acknowledges, and returns read data with a one-cycle completion pulse. A configurable timeout recovers from a slave that never responds. It sits between the core/DMA and the RAM/peripheral address decoder.

## Interface
Parameters:
- TIMEOUT, default 16: maximum ACCESS cycles before forced completion with error. 0 disables the timeout.

Ports:
- clk  input  1  system clock. All state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- m0_req, m1_req  input  1  transaction request from master 0 (CPU) and master 1 (DMA).
- m0_we, m1_we  input  1  1 = write, 0 = read.
- m0_addr, m1_addr  input  32  byte address.
- m0_wdata, m1_wdata  input  32  write data.
- m0_size, m1_size  input  2  access size: 00 = byte, 01 = half, 10 = word.
- m0_gnt, m1_gnt  output  1  one-cycle pulse when the request is accepted.
- m0_done, m1_done  output  1  one-cycle completion pulse.
- m0_err, m1_err  output  1  valid with done; 1 = timed out.
- m0_rdata, m1_rdata  output  32  read data, valid with done.
- busValid  output  1  a bus transaction is active.
- busReady  input  1  slave acknowledge; transfer completes in the cycle it is high.
- busWe  output  1  shared bus write enable, qualified by busValid.
- busAddr, busWData  output  32  shared bus address and write data.
- memSize  output  2  shared bus access size.
- busRData  input  32  slave read data, sampled when busValid and busReady are both high.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset enters IDLE.
- IDLE:
  - If any request is high, select a winner, latch its we/addr/wdata/size into internal registers, set owner, then go to ACCESS.
  - With no request, stay in IDLE.
- Round-robin:
  - If only one master requests, it wins.
  - If both request, the master that did not win last wins.
  - last_winner resets to 1, so the CPU wins the first tie.
  - last_winner updates only on entry to ACCESS.
- ACCESS:
  - busValid = 1. Bus outputs come only from the latched registers; later changes on master inputs are ignored.
  - Owner's gnt = 1 in the first ACCESS cycle only.
  - On busReady = 1: capture busRData (reads only; hold the previous value on writes), err = 0, go to RESP.
  - Else, if TIMEOUT ≠ 0 and the wait counter equals TIMEOUT−1: rdata = 0, err = 1, go to RESP.
  - Else increment the wait counter. The counter is cleared on entry to ACCESS and is wide enough to hold TIMEOUT.
- RESP:
  - Owner's done = 1 for exactly one cycle. Its err and rdata are valid in that cycle.
  - The non-owner's done/err stay 0.
  - Next state is always IDLE.
- Masters hold req until gnt. A req still high after the owner's done pulse is treated as a new transaction.
- When busValid = 0: busWe = 0, busAddr/busWData/memSize hold their last latched values. The slave must ignore them.
- Output reset values: all gnt/done/err = 0, busValid = 0, busWe = 0, busAddr = 0, busWData = 0, memSize = 00, m0_rdata = m1_rdata = 0.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs at reset values. No done pulse is issued for the aborted transaction.
- A request arriving during ACCESS/RESP waits. It is arbitrated in the next IDLE cycle.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- Request high at edge N (state IDLE) → ACCESS and gnt during cycle N+1.
- busReady high in the first ACCESS cycle → done in cycle N+2 → IDLE in cycle N+3.
- Minimum transaction: 3 cycles. Back-to-back throughput: one transaction per 3 cycles + slave wait states.
- Timeout path: ACCESS lasts exactly TIMEOUT cycles, then RESP.
- busReady asserted in the same cycle the timeout would fire: ready wins, err = 0.

## Test plan
- Single CPU read: m0_req, addr 0x0000_0010, size 10, busReady in the first ACCESS cycle with busRData 0x1234_5678 → m0_gnt at N+1, m0_done with m0_rdata 0x1234_5678 and err 0 at N+2, busValid high for exactly 1 cycle.
- Simultaneous requests, held high: m0 and m1 req together → grants alternate M0, M1, M0, M1. Each master's fields appear on busAddr only during its own ACCESS.
- DMA write with 3 wait states: m1_we = 1, addr 0x1000_0004, wdata 0xCAFE_F00D, size 01, busReady on the 4th ACCESS cycle → bus fields stable for all 4 cycles, m1_done with err 0.
- Timeout: TIMEOUT = 16, busReady tied 0 → exactly 16 ACCESS cycles, then m0_done with m0_err = 1 and m0_rdata = 0, then IDLE.
- Late ready vs. timeout: busReady rises in ACCESS cycle 16 → err = 0 and read data captured.
- Reset mid-ACCESS: drive reset low for 1 cycle during a wait state → outputs go to reset values immediately, no done pulse, FSM in IDLE, next tie goes to M0.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the shared CPU data bus (master 0 = core, master 1 = DMA).
// One transaction at a time: IDLE -> ACCESS (until ready or timeout) -> RESP (done pulse).
module bus_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_we,
  input  logic        m1_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m1_wdata,
  input  logic [1:0]  m0_size,
  input  logic [1:0]  m1_size,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_done,
  output logic        m1_done,
  output logic        m0_err,
  output logic        m1_err,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        busValid,
  input  logic        busReady,
  output logic        busWe,
  output logic [31:0] busAddr,
  output logic [31:0] busWData,
  output logic [1:0]  memSize,
  input  logic [31:0] busRData
);

  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] TMAX    = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(32'd1);
  localparam bit            TO_EN   = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t        state_r, state_s;
  logic          owner_r, owner_s;
  logic          last_r, last_s;
  logic          win_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          valid_r, valid_s;
  logic          we_r, we_s;
  logic [31:0]   addr_r, addr_s;
  logic [31:0]   wdata_r, wdata_s;
  logic [1:0]    size_r, size_s;
  logic [1:0]    gnt_r, gnt_s;
  logic [1:0]    done_r, done_s;
  logic [1:0]    err_r, err_s;
  logic [31:0]   rdata0_r, rdata0_s;
  logic [31:0]   rdata1_r, rdata1_s;

  // Next-state and next-output logic; every output is computed here and registered below.
  always_comb begin
    state_s  = state_r;
    owner_s  = owner_r;
    last_s   = last_r;
    cnt_s    = cnt_r;
    win_s    = 1'b0;
    valid_s  = valid_r;
    we_s     = we_r;
    addr_s   = addr_r;
    wdata_s  = wdata_r;
    size_s   = size_r;
    gnt_s    = 2'b00;
    done_s   = 2'b00;
    err_s    = 2'b00;
    rdata0_s = rdata0_r;
    rdata1_s = rdata1_r;
    case (state_r)
      IDLE: begin
        if (m0_req || m1_req) begin
          // On a tie the master that did not win last time goes first.
          if (m0_req && m1_req) begin
            win_s = ~last_r;
          end else if (m1_req) begin
            win_s = 1'b1;
          end else begin
            win_s = 1'b0;
          end
          state_s        = ACCESS;
          owner_s        = win_s;
          last_s         = win_s;
          cnt_s          = '0;
          valid_s        = 1'b1;
          gnt_s[win_s]   = 1'b1;
          if (win_s) begin
            we_s    = m1_we;
            addr_s  = m1_addr;
            wdata_s = m1_wdata;
            size_s  = m1_size;
          end else begin
            we_s    = m0_we;
            addr_s  = m0_addr;
            wdata_s = m0_wdata;
            size_s  = m0_size;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        if (busReady) begin
          state_s         = RESP;
          valid_s         = 1'b0;
          we_s            = 1'b0;
          done_s[owner_r] = 1'b1;
          if (we_r) begin
            rdata0_s = rdata0_r;
            rdata1_s = rdata1_r;
          end else if (owner_r) begin
            rdata1_s = busRData;
          end else begin
            rdata0_s = busRData;
          end
        end else if (TO_EN && (cnt_r == TMAX)) begin
          state_s         = RESP;
          valid_s         = 1'b0;
          we_s            = 1'b0;
          done_s[owner_r] = 1'b1;
          err_s[owner_r]  = 1'b1;
          if (owner_r) begin
            rdata1_s = 32'h0000_0000;
          end else begin
            rdata0_s = 32'h0000_0000;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        valid_s = 1'b0;
        we_s    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction without a done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      owner_r  <= 1'b0;
      last_r   <= 1'b1;
      cnt_r    <= '0;
      valid_r  <= 1'b0;
      we_r     <= 1'b0;
      addr_r   <= 32'h0000_0000;
      wdata_r  <= 32'h0000_0000;
      size_r   <= 2'b00;
      gnt_r    <= 2'b00;
      done_r   <= 2'b00;
      err_r    <= 2'b00;
      rdata0_r <= 32'h0000_0000;
      rdata1_r <= 32'h0000_0000;
    end else begin
      state_r  <= state_s;
      owner_r  <= owner_s;
      last_r   <= last_s;
      cnt_r    <= cnt_s;
      valid_r  <= valid_s;
      we_r     <= we_s;
      addr_r   <= addr_s;
      wdata_r  <= wdata_s;
      size_r   <= size_s;
      gnt_r    <= gnt_s;
      done_r   <= done_s;
      err_r    <= err_s;
      rdata0_r <= rdata0_s;
      rdata1_r <= rdata1_s;
    end
  end

  assign m0_gnt   = gnt_r[0];
  assign m1_gnt   = gnt_r[1];
  assign m0_done  = done_r[0];
  assign m1_done  = done_r[1];
  assign m0_err   = err_r[0];
  assign m1_err   = err_r[1];
  assign m0_rdata = rdata0_r;
  assign m1_rdata = rdata1_r;
  assign busValid = valid_r;
  assign busWe    = we_r;
  assign busAddr  = addr_r;
  assign busWData = wdata_r;
  assign memSize  = size_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a vector table of single transactions plus
// hand-written sequences for held-request alternation and mid-transaction reset.
module tb_bus_arbiter;

  logic        clk, reset;
  logic        m0_req, m1_req, m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [1:0]  m0_size, m1_size;
  logic        m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        busValid, busReady, busWe;
  logic [31:0] busAddr, busWData, busRData;
  logic [1:0]  memSize;

  int ncmp = 0;
  int nfail = 0;

  bus_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_size(m0_size), .m1_size(m1_size),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_done(m0_done), .m1_done(m1_done),
    .m0_err(m0_err), .m1_err(m1_err), .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .busValid(busValid), .busReady(busReady), .busWe(busWe), .busAddr(busAddr),
    .busWData(busWData), .memSize(memSize), .busRData(busRData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r0, r1, we0, we1;
    logic [31:0] a0, a1, d0, d1;
    logic [1:0]  s0, s1;
    int          ready_at;   // ACCESS cycle in which busReady is high, 0 = never
    logic [31:0] rd;
    logic        win;        // expected winner
    int          cyc;        // expected ACCESS cycles
    logic        err;
    logic [31:0] rdata;      // expected rdata of the winner at done
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic r0, input logic r1, input logic we0, input logic we1,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [1:0] s0, input logic [1:0] s1,
                              input int ready_at, input logic [31:0] rd,
                              input logic win, input int cyc, input logic err,
                              input logic [31:0] rdata);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.we0 = we0; v.we1 = we1;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1; v.s0 = s0; v.s1 = s1;
    v.ready_at = ready_at; v.rd = rd;
    v.win = win; v.cyc = cyc; v.err = err; v.rdata = rdata;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    logic [31:0] ea, ed;
    logic [1:0]  es;
    logic        ew;
    int          k;
    bit          busy;
    ea = v.win ? v.a1 : v.a0;
    ed = v.win ? v.d1 : v.d0;
    es = v.win ? v.s1 : v.s0;
    ew = v.win ? v.we1 : v.we0;
    @(negedge clk);
    m0_req = v.r0; m1_req = v.r1; m0_we = v.we0; m1_we = v.we1;
    m0_addr = v.a0; m1_addr = v.a1; m0_wdata = v.d0; m1_wdata = v.d1;
    m0_size = v.s0; m1_size = v.s1; busReady = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("gnt0", m0_gnt, !v.win);
    chk("gnt1", m1_gnt, v.win);
    chk("valid_first", busValid, 1'b1);
    chk("addr_first", busAddr, ea);
    chk("wdata_first", busWData, ed);
    chk("size_first", memSize, es);
    chk("we_first", busWe, ew);
    // Scramble master inputs: the bus must keep showing the latched request.
    m0_req = 1'b0; m1_req = 1'b0;
    m0_addr = ~v.a0; m1_addr = ~v.a1; m0_wdata = ~v.d0; m1_wdata = ~v.d1;
    m0_size = ~v.s0; m1_size = ~v.s1; m0_we = ~v.we0; m1_we = ~v.we1;
    k = 1;
    busy = 1'b1;
    while (busy) begin
      if (k == v.ready_at) begin
        busReady = 1'b1; busRData = v.rd;
      end else begin
        busReady = 1'b0; busRData = 32'hFFFF_FFFF;
      end
      @(posedge clk); @(negedge clk);
      busReady = 1'b0;
      if (busValid && k < 40) begin
        k++;
        chk("addr_hold", busAddr, ea);
        chk("wdata_hold", busWData, ed);
        chk("we_hold", busWe, ew);
        chk("gnt_once", {m1_gnt, m0_gnt}, 2'b00);
      end else begin
        busy = 1'b0;
      end
    end
    chk("access_cycles", k, v.cyc);
    chk("done0", m0_done, !v.win);
    chk("done1", m1_done, v.win);
    chk("err_owner", v.win ? m1_err : m0_err, v.err);
    chk("err_other", v.win ? m0_err : m1_err, 1'b0);
    chk("rdata_owner", v.win ? m1_rdata : m0_rdata, v.rdata);
    chk("valid_resp", busValid, 1'b0);
    chk("we_resp", busWe, 1'b0);
    chk("addr_idle_hold", busAddr, ea);
    @(posedge clk); @(negedge clk);
    chk("done_pulse", {m1_done, m0_done}, 2'b00);
    chk("valid_idle", busValid, 1'b0);
  endtask

  initial begin
    logic exp_w [4];
    bit   saw_done;

    reset = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
    m0_addr = 32'h0; m1_addr = 32'h0; m0_wdata = 32'h0; m1_wdata = 32'h0;
    m0_size = 2'b00; m1_size = 2'b00; busReady = 1'b0; busRData = 32'h0;

    //         r0    r1    we0   we1   a0             a1             d0             d1             s0     s1     rdy rd             win   cyc err   rdata
    vt[0] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0,        32'h0,         32'h0,         2'b10, 2'b00, 1,  32'h1234_5678, 1'b0, 1,  1'b0, 32'h1234_5678);
    vt[1] = mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h0,         32'h1000_0004, 32'h0,         32'hCAFE_F00D, 2'b00, 2'b01, 4,  32'hDEAD_BEEF, 1'b1, 4,  1'b0, 32'h0000_0000);
    vt[2] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0020, 32'h0,        32'h0,         32'h0,         2'b10, 2'b00, 0,  32'h0,         1'b0, 16, 1'b1, 32'h0000_0000);
    vt[3] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0024, 32'h0,        32'h0,         32'h0,         2'b10, 2'b00, 16, 32'hA5A5_5A5A, 1'b0, 16, 1'b0, 32'hA5A5_5A5A);
    vt[4] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0000_0003, 32'h0,         32'h0,         2'b00, 2'b00, 2,  32'h0000_00FF, 1'b1, 2,  1'b0, 32'h0000_00FF);
    vt[5] = mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0030, 32'h0,        32'h1111_2222, 32'h0,         2'b10, 2'b00, 1,  32'h0000_9999, 1'b0, 1,  1'b0, 32'hA5A5_5A5A);
    vt[6] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0000_0034, 32'h0,         32'h0,         2'b00, 2'b10, 0,  32'h0,         1'b1, 16, 1'b1, 32'h0000_0000);
    vt[7] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_0080, 32'h0,         32'h0,         2'b10, 2'b10, 1,  32'h0BAD_F00D, 1'b0, 1,  1'b0, 32'h0BAD_F00D);
    vt[8] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0044, 32'h0000_0084, 32'h0,         32'h0,         2'b01, 2'b00, 3,  32'h7777_8888, 1'b1, 3,  1'b0, 32'h7777_8888);

    repeat (2) @(negedge clk);
    chk("rst_valid", busValid, 1'b0);
    chk("rst_flags", {m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, busWe}, 7'b0);
    chk("rst_addr", busAddr, 32'h0);
    chk("rst_wdata", busWData, 32'h0);
    chk("rst_size", memSize, 2'b00);
    chk("rst_rdata0", m0_rdata, 32'h0);
    chk("rst_rdata1", m1_rdata, 32'h0);
    reset = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vt[i]);

    // Both requests held high: last winner was M1, so grants go M0, M1, M0, M1.
    exp_w[0] = 1'b0; exp_w[1] = 1'b1; exp_w[2] = 1'b0; exp_w[3] = 1'b1;
    @(negedge clk);
    m0_we = 1'b0; m1_we = 1'b0; m0_addr = 32'h0000_0100; m1_addr = 32'h0000_0200;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(posedge clk); @(negedge clk);
      chk("alt_gnt", {m1_gnt, m0_gnt}, exp_w[t] ? 2'b10 : 2'b01);
      chk("alt_addr", busAddr, exp_w[t] ? 32'h0000_0200 : 32'h0000_0100);
      busReady = 1'b1; busRData = 32'h5000_0000 + t;
      @(posedge clk); @(negedge clk);
      busReady = 1'b0;
      chk("alt_done", {m1_done, m0_done}, exp_w[t] ? 2'b10 : 2'b01);
      @(posedge clk); @(negedge clk);
      chk("alt_idle", busValid, 1'b0);
      if (t == 3) begin
        m0_req = 1'b0; m1_req = 1'b0;
      end
    end

    // Reset during a wait state: M0 wins (last becomes M0), reset must restore M0 tie priority.
    @(negedge clk);
    m0_req = 1'b1; m0_addr = 32'h0000_0300; m0_wdata = 32'h1234_0000; m0_size = 2'b10;
    @(posedge clk); @(negedge clk);
    chk("mr_gnt", m0_gnt, 1'b1);
    m0_req = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("mr_waiting", busValid, 1'b1);
    reset = 1'b0;
    #1;
    chk("mr_valid", busValid, 1'b0);
    chk("mr_flags", {m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, busWe}, 7'b0);
    chk("mr_addr", busAddr, 32'h0);
    chk("mr_wdata", busWData, 32'h0);
    chk("mr_size", memSize, 2'b00);
    chk("mr_rdata0", m0_rdata, 32'h0);
    chk("mr_rdata1", m1_rdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (m0_done || m1_done || busValid) saw_done = 1'b1;
    end
    chk("mr_no_done", saw_done, 1'b0);
    m0_req = 1'b1; m1_req = 1'b1; m0_addr = 32'h0000_0400; m1_addr = 32'h0000_0500;
    @(posedge clk); @(negedge clk);
    chk("mr_tie_gnt", {m1_gnt, m0_gnt}, 2'b01);
    chk("mr_tie_addr", busAddr, 32'h0000_0400);
    m0_req = 1'b0; m1_req = 1'b0;
    busReady = 1'b1; busRData = 32'h600D_0001;
    @(posedge clk); @(negedge clk);
    busReady = 1'b0;
    chk("mr_tie_done", m0_done, 1'b1);
    chk("mr_tie_rdata", m0_rdata, 32'h600D_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
